// File: rtl/uart_frame_rx_ctrl.sv
// uart_frame_rx_ctrl
// Frames the UART_RX byte stream (SYNC, LEN, LEN payload bytes, CHK) into
// 32-bit little-endian words for the user register bank. A good frame is
// held, with o_frame_valid high, until the consumer pulses i_ack.
//
// Ports:
//   clk_clk        system clock
//   reset_reset    asynchronous reset, active-high
//   i_rx_dv        one-cycle byte strobe from UART_RX
//   i_rx_byte      received byte
//   i_ack          consumer acknowledge, releases a held frame
//   o_wr_en        one-cycle register bank write strobe
//   o_wr_addr      word index 0..15
//   o_wr_data      packed word, unused upper lanes zero
//   o_frame_valid  good frame held in the bank
//   o_frame_len    payload byte count of the held frame
//   o_err_code     last error: 0 none, 1 length, 2 checksum, 3 timeout, 4 overrun
//   o_err_cnt      saturating error count
//   o_busy         frame in progress (LEN/PAYLOAD/CHK)
//
// state   | meaning
// IDLE    | hunting for SYNC_BYTE, other bytes ignored
// LEN     | waiting for the length byte
// PAYLOAD | packing payload bytes into words
// CHK     | waiting for the checksum byte
// HOLD    | good frame held until i_ack
module uart_frame_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 64,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_ack,
  output logic        o_wr_en,
  output logic [3:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_frame_valid,
  output logic [6:0]  o_frame_len,
  output logic [2:0]  o_err_code,
  output logic [7:0]  o_err_cnt,
  output logic        o_busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam logic [2:0] E_LEN = 3'd1;
  localparam logic [2:0] E_CHK = 3'd2;
  localparam logic [2:0] E_TMO = 3'd3;
  localparam logic [2:0] E_OVR = 3'd4;

  // Down-counter loaded on every byte; reaching zero with no byte means the
  // idle count has hit TIMEOUT_CLKS-1 clocks since the last dv.
  localparam int         TW       = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CLKS - 2);

  logic [2:0]    state;
  logic [6:0]    len;
  logic [5:0]    idx;
  logic [31:0]   acc;
  logic [7:0]    sum;
  logic [TW-1:0] tmo;

  logic [31:0] word_next;
  logic [7:0]  sum_next;
  logic        last;
  logic        len_bad;
  logic        tmo_done;
  logic        err_evt;
  logic [2:0]  err_val;

  assign word_next = acc | (32'(i_rx_byte) << {idx[1:0], 3'b000});
  assign sum_next  = sum + i_rx_byte;
  assign last      = ({1'b0, idx} == (len - 7'd1));
  assign len_bad   = (i_rx_byte == 8'd0) || (i_rx_byte > 8'(MAX_LEN));
  assign tmo_done  = (tmo == '0);
  assign o_busy    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);

  always_comb begin
    err_evt = 1'b0;
    err_val = 3'd0;
    case (state)
      S_LEN: begin
        if (i_rx_dv && len_bad) begin
          err_evt = 1'b1;
          err_val = E_LEN;
        end else if (!i_rx_dv && tmo_done) begin
          err_evt = 1'b1;
          err_val = E_TMO;
        end
      end
      S_PAYLOAD: begin
        if (!i_rx_dv && tmo_done) begin
          err_evt = 1'b1;
          err_val = E_TMO;
        end
      end
      S_CHK: begin
        if (i_rx_dv && sum_next != 8'd0) begin
          err_evt = 1'b1;
          err_val = E_CHK;
        end else if (!i_rx_dv && tmo_done) begin
          err_evt = 1'b1;
          err_val = E_TMO;
        end
      end
      S_HOLD: begin
        // ack wins over a simultaneous byte: the byte is dropped silently
        if (i_rx_dv && !i_ack) begin
          err_evt = 1'b1;
          err_val = E_OVR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state         <= S_IDLE;
      len           <= 7'd0;
      idx           <= 6'd0;
      acc           <= 32'd0;
      sum           <= 8'd0;
      tmo           <= '0;
      o_wr_en       <= 1'b0;
      o_wr_addr     <= 4'd0;
      o_wr_data     <= 32'd0;
      o_frame_valid <= 1'b0;
      o_frame_len   <= 7'd0;
      o_err_code    <= 3'd0;
      o_err_cnt     <= 8'd0;
    end else begin
      o_wr_en <= 1'b0;

      if (o_busy) begin
        if (i_rx_dv) tmo <= TMO_LOAD;
        else if (!tmo_done) tmo <= tmo - 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (i_rx_dv && i_rx_byte == SYNC_BYTE) begin
            state <= S_LEN;
            sum   <= 8'd0;
            idx   <= 6'd0;
            acc   <= 32'd0;
            tmo   <= TMO_LOAD;
          end
        end
        S_LEN: begin
          if (i_rx_dv) begin
            if (len_bad) begin
              state <= S_IDLE;
            end else begin
              len   <= i_rx_byte[6:0];
              sum   <= i_rx_byte;
              state <= S_PAYLOAD;
            end
          end else if (tmo_done) begin
            state <= S_IDLE;
          end
        end
        S_PAYLOAD: begin
          if (i_rx_dv) begin
            sum <= sum_next;
            idx <= idx + 6'd1;
            if (idx[1:0] == 2'd3 || last) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= idx[5:2];
              o_wr_data <= word_next;
              acc       <= 32'd0;
            end else begin
              acc <= word_next;
            end
            if (last) state <= S_CHK;
          end else if (tmo_done) begin
            state <= S_IDLE;
          end
        end
        S_CHK: begin
          if (i_rx_dv) begin
            if (sum_next == 8'd0) begin
              state         <= S_HOLD;
              o_frame_valid <= 1'b1;
              o_frame_len   <= len;
            end else begin
              state <= S_IDLE;
            end
          end else if (tmo_done) begin
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (i_ack) begin
            state         <= S_IDLE;
            o_frame_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // ack clears the error code; an error in the same cycle overrides it
      if (i_ack) o_err_code <= 3'd0;
      if (err_evt) begin
        o_err_code <= err_val;
        if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx_ctrl.sv
module tb_uart_frame_rx_ctrl;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv = 1'b0;
  logic [7:0]  rxb = 8'd0;
  logic        ack = 1'b0;
  logic        o_wr_en;
  logic [3:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_frame_valid;
  logic [6:0]  o_frame_len;
  logic [2:0]  o_err_code;
  logic [7:0]  o_err_cnt;
  logic        o_busy;

  uart_frame_rx_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(64), .TIMEOUT_CLKS(TMO)) dut (
    .clk_clk(clk), .reset_reset(rst), .i_rx_dv(dv), .i_rx_byte(rxb), .i_ack(ack),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_frame_valid(o_frame_valid), .o_frame_len(o_frame_len),
    .o_err_code(o_err_code), .o_err_cnt(o_err_cnt), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the bytes of the frame in progress as a list and derives the
  // expected registered outputs after each clock edge.
  bit          m_act, m_hold;
  int          q[$];
  int          m_idle;
  logic        e_wr_en;
  logic [3:0]  e_addr;
  logic [31:0] e_data;
  logic        e_fv;
  logic [6:0]  e_len;
  logic [2:0]  e_err;
  logic [7:0]  e_cnt;

  task automatic m_error(input int c);
    e_err = 3'(c);
    if (e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
  endtask

  task automatic m_reset();
    m_act = 0; m_hold = 0; q.delete(); m_idle = 0;
    e_wr_en = 0; e_addr = 0; e_data = 0; e_fv = 0; e_len = 0; e_err = 0; e_cnt = 0;
  endtask

  task automatic m_step(input logic d, input logic [7:0] b, input logic a);
    int i, s, base;
    e_wr_en = 0;
    if (m_hold) begin
      if (a) begin m_hold = 0; e_fv = 0; e_err = 0; end
      else if (d) m_error(4);
    end else if (!m_act) begin
      if (a) e_err = 0;
      if (d && b == 8'hA5) begin m_act = 1; q.delete(); m_idle = 0; end
    end else begin
      if (a) e_err = 0;
      if (d) begin
        m_idle = 0;
        if (q.size() == 0) begin
          if (b == 0 || b > 64) begin m_act = 0; m_error(1); end
          else q.push_back(int'(b));
        end else if (q.size() - 1 < q[0]) begin
          q.push_back(int'(b));
          i = q.size() - 2;
          if (i % 4 == 3 || i == q[0] - 1) begin
            base = i - i % 4;
            e_wr_en = 1; e_addr = 4'(i / 4); e_data = 0;
            for (int k = base; k <= i; k++) e_data = e_data | (32'(q[k+1]) << (8 * (k % 4)));
          end
        end else begin
          s = int'(b);
          foreach (q[j]) s += q[j];
          m_act = 0;
          if (s % 256 == 0) begin m_hold = 1; e_fv = 1; e_len = 7'(q[0]); end
          else m_error(2);
        end
      end else begin
        m_idle++;
        if (m_idle == TMO - 1) begin m_act = 0; m_error(3); end
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step(dv, rxb, ack);
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  logic [3:0]  wlog_addr[$];
  logic [31:0] wlog_data[$];

  initial begin
    forever begin
      @(negedge clk);
      chk("wr_en", 32'(o_wr_en), 32'(e_wr_en));
      if (e_wr_en) begin
        chk("wr_addr", 32'(o_wr_addr), 32'(e_addr));
        chk("wr_data", o_wr_data, e_data);
      end
      chk("frame_valid", 32'(o_frame_valid), 32'(e_fv));
      if (e_fv) chk("frame_len", 32'(o_frame_len), 32'(e_len));
      chk("err_code", 32'(o_err_code), 32'(e_err));
      chk("err_cnt", 32'(o_err_cnt), 32'(e_cnt));
      chk("busy", 32'(o_busy), 32'(m_act));
      if (o_wr_en) begin wlog_addr.push_back(o_wr_addr); wlog_data.push_back(o_wr_data); end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pl[64];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    dv = 1'b1; rxb = b;
    @(negedge clk);
    dv = 1'b0; rxb = 8'($urandom);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic gap(input int gmax);
    if (gmax > 0) tick($urandom_range(0, gmax));
  endtask

  task automatic send_frame(input int len, input bit good, input int gmax);
    int s;
    s = len;
    send(8'hA5); gap(gmax);
    send(8'(len)); gap(gmax);
    for (int i = 0; i < len; i++) begin send(pl[i]); s += int'(pl[i]); gap(gmax); end
    send(8'((256 - s % 256) + (good ? 0 : 1)));
  endtask

  task automatic clear_log();
    wlog_addr.delete(); wlog_data.delete();
  endtask

  initial begin
    int cnt_before, len, act;
    tick(2);
    chk("rst_wr_en", 32'(o_wr_en), 0);
    chk("rst_wr_addr", 32'(o_wr_addr), 0);
    chk("rst_wr_data", o_wr_data, 0);
    chk("rst_fv", 32'(o_frame_valid), 0);
    chk("rst_len", 32'(o_frame_len), 0);
    chk("rst_err", 32'(o_err_code), 0);
    chk("rst_cnt", 32'(o_err_cnt), 0);
    chk("rst_busy", 32'(o_busy), 0);
    rst = 1'b0;
    tick(2);

    // 1: good 5-byte frame; checksum 0xFC makes 5+0xFF+CHK = 0 mod 256
    clear_log();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44; pl[4] = 8'h55;
    send_frame(5, 1'b1, 0);
    tick(1);
    chk("t1_nwr", wlog_addr.size(), 2);
    if (wlog_addr.size() == 2) begin
      chk("t1_a0", 32'(wlog_addr[0]), 0); chk("t1_d0", wlog_data[0], 32'h44332211);
      chk("t1_a1", 32'(wlog_addr[1]), 1); chk("t1_d1", wlog_data[1], 32'h00000055);
    end
    chk("t1_fv", 32'(o_frame_valid), 1);
    chk("t1_len", 32'(o_frame_len), 5);
    chk("t1_err", 32'(o_err_code), 0);
    pulse_ack();
    chk("t1_fv_ack", 32'(o_frame_valid), 0);

    // 2: bad checksum
    clear_log();
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    tick(1);
    chk("t2_nwr", wlog_addr.size(), 1);
    if (wlog_addr.size() == 1) chk("t2_d0", wlog_data[0], 32'h00002010);
    chk("t2_fv", 32'(o_frame_valid), 0);
    chk("t2_err", 32'(o_err_code), 2);
    chk("t2_cnt", 32'(o_err_cnt), 1);

    // 3: bad lengths, then a good frame
    clear_log();
    send(8'hA5); send(8'h00); tick(1);
    chk("t3_err0", 32'(o_err_code), 1);
    send(8'hA5); send(8'h41); tick(1);
    chk("t3_err41", 32'(o_err_code), 1);
    chk("t3_cnt", 32'(o_err_cnt), 3);
    chk("t3_nwr", wlog_addr.size(), 0);
    chk("t3_busy", 32'(o_busy), 0);
    pl[0] = 8'hA5; pl[1] = 8'h01;
    send_frame(2, 1'b1, 1);
    tick(1);
    chk("t3_fv", 32'(o_frame_valid), 1);
    pulse_ack();

    // 4: timeout exactly TMO-1 idle clocks after the last byte
    send(8'hA5); send(8'h03); send(8'h01);
    tick(98);
    chk("t4_busy98", 32'(o_busy), 1);
    tick(1);
    chk("t4_busy99", 32'(o_busy), 0);
    chk("t4_err", 32'(o_err_code), 3);
    send(8'hA5); send(8'h03); send(8'h01);
    tick(97);
    send(8'h02);
    chk("t4_alive", 32'(o_busy), 1);
    tick(5);
    send(8'h03); send(8'hF7);
    tick(1);
    chk("t4_fv", 32'(o_frame_valid), 1);
    chk("t4_len", 32'(o_frame_len), 3);
    pulse_ack();

    // 5: maximum frame, overrun, ack+dv collision
    clear_log();
    for (int i = 0; i < 64; i++) pl[i] = 8'(i);
    send_frame(64, 1'b1, 1);
    tick(1);
    chk("t5_nwr", wlog_addr.size(), 16);
    if (wlog_addr.size() == 16) begin
      chk("t5_a15", 32'(wlog_addr[15]), 15);
      chk("t5_d15", wlog_data[15], 32'h3F3E3D3C);
    end
    chk("t5_len", 32'(o_frame_len), 64);
    chk("t5_model_len", 32'(e_len), 64);
    send(8'h77);
    chk("t5_ovr", 32'(o_err_code), 4);
    chk("t5_fv", 32'(o_frame_valid), 1);
    cnt_before = int'(o_err_cnt);
    chk("t5_model_cnt", 32'(e_cnt), 32'(cnt_before));
    ack = 1'b1; dv = 1'b1; rxb = 8'h12;
    @(negedge clk);
    ack = 1'b0; dv = 1'b0;
    chk("t5_fv_col", 32'(o_frame_valid), 0);
    chk("t5_cnt_col", 32'(o_err_cnt), 32'(cnt_before));

    // 6: async reset mid-payload
    send(8'hA5); send(8'h08); send(8'h01); send(8'h02);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_wr_en", 32'(o_wr_en), 0);
    chk("t6_fv", 32'(o_frame_valid), 0);
    chk("t6_err", 32'(o_err_code), 0);
    chk("t6_cnt", 32'(o_err_cnt), 0);
    chk("t6_busy", 32'(o_busy), 0);
    chk("t6_data", o_wr_data, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
    send_frame(8, 1'b1, 2);
    tick(1);
    chk("t6_fv_after", 32'(o_frame_valid), 1);
    pulse_ack();
    for (int i = 0; i < 300; i++) begin send(8'hA5); send(8'h00); end
    tick(1);
    chk("t6_sat", 32'(o_err_cnt), 255);

    // random traffic against the model
    for (int n = 0; n < 150; n++) begin
      act = int'($urandom_range(0, 19));
      if (act == 0) begin
        send(8'hA5); send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(65, 255)));
      end else if (act == 1) begin
        send(8'hA5); send(8'h04); send(8'($urandom)); tick(TMO + $urandom_range(0, 3));
      end else if (act == 2) begin
        send(8'($urandom)); pulse_ack();
      end else begin
        len = int'($urandom_range(1, 64));
        for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
        send_frame(len, $urandom_range(0, 3) != 0, 3);
      end
      gap(3);
      case ($urandom_range(0, 3))
        0: pulse_ack();
        1: begin send(8'($urandom)); pulse_ack(); end
        2: begin ack = 1'b1; dv = 1'b1; rxb = 8'($urandom); @(negedge clk); ack = 1'b0; dv = 1'b0; end
        default: ;
      endcase
    end
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
